// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ssd_pkg
// Description : Shared types and constants for the seven-segment scan
//               controller: nibble type, blank cathode pattern and the
//               active-low hex segment table.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // One hex digit of display data
    typedef logic [3:0] nibble_t;

    // All cathodes released (every segment and the dp off)
    localparam logic [7:0] SSD_OFF = 8'hFF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; entry n is
    // SSD_SEG_LUT[n], listed here from F down to 0
    localparam logic [15:0][6:0] SSD_SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage
`default_nettype wire

// File: rtl/ssd_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_hex_decoder
// Description : Combinational nibble to active-low seven-segment conversion,
//               with the decimal point folded into cathode bit 7.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  nibble_t    nibble_i,
    input  logic       dp_i,
    output logic [7:0] cathodes_o
);

    // Table lookup for the segments; dp is active-low like the segments
    always_comb begin
        cathodes_o = {~dp_i, SSD_SEG_LUT[nibble_i]};
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Multiplexed seven-segment display scanner. A slot counter
//               times each digit, a digit index walks the anodes, brightness
//               gates the on-time inside each slot, and a pending/active
//               double buffer swaps only at the frame boundary so a frame is
//               never torn.
// Config      : define SSD_LZB_EN to blank leading zero digits (digit 0 is
//               always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 8,    // 1..16
    parameter int SLOT_LOG2  = 16    // 4..24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              cathodes,
    output logic                    frame_done
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [SLOT_LOG2-1:0]    slot_cnt_q;
    logic [IDX_W-1:0]        digit_idx_q;

    // Frame buffers and handshake
    logic [4*NUM_DIGITS-1:0] pend_data_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic [4*NUM_DIGITS-1:0] act_data_q;
    logic [NUM_DIGITS-1:0]   act_dp_q;
    logic                    load_ready_q;
    logic                    frame_done_q;

    // Registered display outputs and their next-state values
    logic [NUM_DIGITS-1:0]   anodes_q;
    logic [NUM_DIGITS-1:0]   anodes_d;
    logic [7:0]              cathodes_q;
    logic [7:0]              cathodes_d;

    // Combinational helpers
    logic                    slot_wrap;
    logic                    frame_end;
    logic                    accept;
    logic                    lit;
    nibble_t                 sel_nibble;
    logic                    sel_dp;
    logic                    sel_blank;

    assign slot_wrap = &slot_cnt_q;
    assign frame_end = slot_wrap && (digit_idx_q == LAST_IDX);
    assign accept    = load_valid && load_ready_q;

    // Pull the current digit's nibble and dp out of the active buffer
    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                sel_nibble = act_data_q[4*i +: 4];
                sel_dp     = act_dp_q[i];
            end
        end
    end

`ifdef SSD_LZB_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // Walk down from the top digit: a digit is blank while it and every
    // digit above it is zero with dp clear; digit 0 always shows
    always_comb begin : b_lz_scan
        logic run;
        run      = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run         = run & (act_data_q[4*i +: 4] == 4'h0) & ~act_dp_q[i];
            lz_blank[i] = run;
        end
        lz_blank[0] = 1'b0;
    end

    // Blank flag of the digit currently being scanned
    always_comb begin
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                sel_blank = lz_blank[i];
            end
        end
    end
`else
    assign sel_blank = 1'b0;
`endif

    // On-time inside the slot is set by the top four slot-counter bits
    assign lit = (slot_cnt_q[SLOT_LOG2-1 -: 4] <= brightness) && !sel_blank;

    // One-hot active-low anode for the current digit while it is lit
    always_comb begin
        anodes_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (digit_idx_q == IDX_W'(i))) begin
                anodes_d[i] = 1'b0;
            end
        end
    end

    ssd_hex_decoder u_hex_decoder (
        .nibble_i   (sel_nibble),
        .dp_i       (sel_dp),
        .cathodes_o (cathodes_d)
    );

    // Scan counters, frame buffers, handshake and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            load_ready_q <= 1'b1;
            frame_done_q <= 1'b0;
            anodes_q     <= '1;
            cathodes_q   <= SSD_OFF;
        end else begin
            slot_cnt_q <= slot_cnt_q + SLOT_LOG2'(1);
            if (slot_wrap) begin
                digit_idx_q <= (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + IDX_W'(1);
            end
            // The copy uses the pre-edge pending value, so a frame accepted
            // on the boundary cycle waits for the next boundary
            if (frame_end) begin
                act_data_q <= pend_data_q;
                act_dp_q   <= pend_dp_q;
            end
            if (accept) begin
                pend_data_q <= load_data;
                pend_dp_q   <= load_dp;
            end
            if (accept) begin
                load_ready_q <= 1'b0;
            end else if (frame_end) begin
                load_ready_q <= 1'b1;
            end
            frame_done_q <= frame_end;
            anodes_q     <= anodes_d;
            cathodes_q   <= cathodes_d;
        end
    end

    assign load_ready = load_ready_q;
    assign frame_done = frame_done_q;
    assign anodes     = anodes_q;
    assign cathodes   = cathodes_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_ctrl
// Description : Self-checking bench for ssd_scan_ctrl (8-digit and 3-digit
//               instances, 16-cycle slots) against a time-based reference
//               model. Honours SSD_LZB_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

    localparam int N     = 8;
    localparam int SL    = 4;
    localparam int SLOT  = 1 << SL;
    localparam int FRAME = SLOT * N;
`ifdef SSD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [7:0]  load_dp;
    logic [3:0]  brightness;
    logic [7:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame_done;

    logic        load_valid3;
    logic        load_ready3;
    logic [11:0] load_data3;
    logic [2:0]  load_dp3;
    logic [3:0]  brightness3;
    logic [2:0]  anodes3;
    logic [7:0]  cathodes3;
    logic        frame_done3;

    int checks = 0;
    int errors = 0;

    // Reference model state; t counts cycles since reset release
    int          t;
    logic [31:0] m_pend_data, m_act_data;
    logic [7:0]  m_pend_dp, m_act_dp;
    logic        m_ready;
    logic [7:0]  exp_an, exp_cat;
    logic        exp_fd;
    logic [2:0]  exp3_an;
    logic        exp3_fd;

    ssd_scan_ctrl #(.NUM_DIGITS(N), .SLOT_LOG2(SL)) u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .brightness(brightness),
        .anodes(anodes), .cathodes(cathodes), .frame_done(frame_done)
    );

    ssd_scan_ctrl #(.NUM_DIGITS(3), .SLOT_LOG2(SL)) u_dut3 (
        .clk(clk), .reset(reset), .load_valid(load_valid3), .load_ready(load_ready3),
        .load_data(load_data3), .load_dp(load_dp3), .brightness(brightness3),
        .anodes(anodes3), .cathodes(cathodes3), .frame_done(frame_done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segments {g..a} from the familiar lit-segment patterns
    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] on_segs;
        case (v)
            4'h0: on_segs = 7'h3F; 4'h1: on_segs = 7'h06; 4'h2: on_segs = 7'h5B; 4'h3: on_segs = 7'h4F;
            4'h4: on_segs = 7'h66; 4'h5: on_segs = 7'h6D; 4'h6: on_segs = 7'h7D; 4'h7: on_segs = 7'h07;
            4'h8: on_segs = 7'h7F; 4'h9: on_segs = 7'h6F; 4'hA: on_segs = 7'h77; 4'hB: on_segs = 7'h7C;
            4'hC: on_segs = 7'h39; 4'hD: on_segs = 7'h5E; 4'hE: on_segs = 7'h79; default: on_segs = 7'h71;
        endcase
        return ~on_segs;
    endfunction

    // Leading-zero rule: digit dig and all above it are zero with dp clear
    function automatic bit blanked(input logic [63:0] d, input logic [15:0] dp, input int n, input int dig);
        bit all_zero;
        all_zero = 1'b1;
        for (int j = dig; j < n; j++) begin
            if (d[4*j +: 4] != 4'h0 || dp[j]) all_zero = 1'b0;
        end
        return LZB && (dig != 0) && all_zero;
    endfunction

    // Advance the model by one cycle from the current inputs, then clock
    task automatic tick();
        int slot, dig, d3;
        bit bnd, acc, on;
        logic [11:0] act3;
        if (reset) begin
            t = 0;
            m_pend_data = '0; m_pend_dp = '0; m_act_data = '0; m_act_dp = '0;
            m_ready = 1'b1;
            exp_an = 8'hFF; exp_cat = 8'hFF; exp_fd = 1'b0;
            exp3_an = 3'b111; exp3_fd = 1'b0;
        end else begin
            slot = t % SLOT;
            dig  = (t / SLOT) % N;
            bnd  = (t % FRAME) == FRAME - 1;
            acc  = load_valid && m_ready;
            on   = (slot >> (SL - 4)) <= int'(brightness);
            exp_an = 8'hFF;
            if (on && !blanked(64'(m_act_data), 16'(m_act_dp), N, dig)) exp_an[dig] = 1'b0;
            exp_cat = {~m_act_dp[dig], seg(m_act_data[4*dig +: 4])};
            exp_fd  = bnd;
            // 3-digit instance always offers 321; first copy lands at t=48
            d3   = (t / SLOT) % 3;
            act3 = (t >= 3 * SLOT) ? 12'h321 : 12'h000;
            exp3_an = 3'b111;
            if (!blanked(64'(act3), 16'h0, 3, d3)) exp3_an[d3] = 1'b0;
            exp3_fd = (t % (3 * SLOT)) == 3 * SLOT - 1;
            if (bnd) begin
                m_act_data = m_pend_data;
                m_act_dp   = m_pend_dp;
            end
            if (acc) begin
                m_pend_data = load_data;
                m_pend_dp   = load_dp;
                m_ready     = 1'b0;
            end else if (bnd) begin
                m_ready = 1'b1;
            end
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        load_valid = 1'b0;
        brightness = 4'hF;
        reset = 1'b1;
        tick();
        checks++;
        if ({anodes, cathodes, frame_done, load_ready} !== {8'hFF, 8'hFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got an=%h cat=%h fd=%b rdy=%b, expected an=ff cat=ff fd=0 rdy=1",
                     anodes, cathodes, frame_done, load_ready);
        end
        checks++;
        if ({anodes3, frame_done3, load_ready3} !== {3'b111, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values3: got an=%b fd=%b rdy=%b, expected an=111 fd=0 rdy=1",
                     anodes3, frame_done3, load_ready3);
        end
        reset = 1'b0;
    endtask

    // Full-brightness frame 8765_4321 scanned for two frames
    task automatic test_basic_scan();
        do_reset();
        brightness = 4'hF;
        load_valid = 1'b1;
        load_data  = 32'h8765_4321;
        load_dp    = 8'h00;
        for (int c = 0; c < 2 * FRAME + 2; c++) begin
            tick();
            load_valid = 1'b0;
            checks++;
            if ({anodes, cathodes, frame_done, load_ready} !== {exp_an, exp_cat, exp_fd, m_ready}) begin
                errors++;
                $display("FAIL basic_scan t=%0d: got an=%h cat=%h fd=%b rdy=%b, expected an=%h cat=%h fd=%b rdy=%b",
                         t, anodes, cathodes, frame_done, load_ready, exp_an, exp_cat, exp_fd, m_ready);
            end
        end
    endtask

    // Brightness 3: four lit cycles per 16-cycle slot
    task automatic test_brightness();
        int lit_cycles;
        lit_cycles = 0;
        brightness = 4'd3;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            if (anodes != 8'hFF) lit_cycles++;
            checks++;
            if ({anodes, cathodes, frame_done, load_ready} !== {exp_an, exp_cat, exp_fd, m_ready}) begin
                errors++;
                $display("FAIL brightness t=%0d: got an=%h cat=%h fd=%b rdy=%b, expected an=%h cat=%h fd=%b rdy=%b",
                         t, anodes, cathodes, frame_done, load_ready, exp_an, exp_cat, exp_fd, m_ready);
            end
        end
        checks++;
        if (lit_cycles != 4 * N) begin
            errors++;
            $display("FAIL brightness_duty: got %0d lit cycles per frame, expected %0d", lit_cycles, 4 * N);
        end
        brightness = 4'hF;
    endtask

    // Offer a frame exactly on the boundary cycle
    task automatic test_boundary_load();
        int ready_low;
        bit found;
        found = 1'b0;
        ready_low = 0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            if ((t % FRAME) == FRAME - 1 && m_ready) begin
                found = 1'b1;
            end else begin
                tick();
                checks++;
                if ({anodes, cathodes, frame_done, load_ready} !== {exp_an, exp_cat, exp_fd, m_ready}) begin
                    errors++;
                    $display("FAIL boundary_wait t=%0d: got an=%h cat=%h fd=%b rdy=%b, expected an=%h cat=%h fd=%b rdy=%b",
                             t, anodes, cathodes, frame_done, load_ready, exp_an, exp_cat, exp_fd, m_ready);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL boundary_timeout: got no boundary with ready=1, expected one within %0d cycles", 2 * FRAME);
        end
        load_valid = 1'b1;
        load_data  = $urandom | 32'h1000_0000;
        load_dp    = 8'($urandom);
        for (int c = 0; c < FRAME + 4; c++) begin
            tick();
            load_valid = 1'b0;
            if (!load_ready) ready_low++;
            checks++;
            if ({anodes, cathodes, frame_done, load_ready} !== {exp_an, exp_cat, exp_fd, m_ready}) begin
                errors++;
                $display("FAIL boundary_load t=%0d: got an=%h cat=%h fd=%b rdy=%b, expected an=%h cat=%h fd=%b rdy=%b",
                         t, anodes, cathodes, frame_done, load_ready, exp_an, exp_cat, exp_fd, m_ready);
            end
        end
        checks++;
        if (ready_low != FRAME) begin
            errors++;
            $display("FAIL boundary_ready_low: got %0d cycles, expected %0d", ready_low, FRAME);
        end
    endtask

    // Reset mid-slot while an all-F frame with dp is pending
    task automatic test_reset_mid();
        int f_seen;
        f_seen = 0;
        load_valid = 1'b1;
        load_data  = 32'hFFFF_FFFF;
        load_dp    = 8'hFF;
        tick();
        load_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({anodes, cathodes, frame_done, load_ready} !== {8'hFF, 8'hFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got an=%h cat=%h fd=%b rdy=%b, expected an=ff cat=ff fd=0 rdy=1",
                     anodes, cathodes, frame_done, load_ready);
        end
        for (int c = 0; c < FRAME + 8; c++) begin
            tick();
            if (cathodes == {1'b0, seg(4'hF)}) f_seen++;
            checks++;
            if ({anodes, cathodes, frame_done, load_ready} !== {exp_an, exp_cat, exp_fd, m_ready}) begin
                errors++;
                $display("FAIL reset_mid_run t=%0d: got an=%h cat=%h fd=%b rdy=%b, expected an=%h cat=%h fd=%b rdy=%b",
                         t, anodes, cathodes, frame_done, load_ready, exp_an, exp_cat, exp_fd, m_ready);
            end
        end
        checks++;
        if (f_seen != 0) begin
            errors++;
            $display("FAIL reset_mid_discard: got %0d cycles showing the discarded frame, expected 0", f_seen);
        end
    endtask

    // Leading-zero pattern 0000_0400, then with dp on digit 5
    task automatic test_lzb();
        int lit_cycles;
        logic [7:0] dp_pat [2];
        int expected [2];
        dp_pat[0] = 8'h00;
        dp_pat[1] = 8'h20;
        expected[0] = LZB ? 3 * SLOT : FRAME;
        expected[1] = LZB ? 6 * SLOT : FRAME;
        do_reset();
        brightness = 4'hF;
        for (int p = 0; p < 2; p++) begin
            load_valid = 1'b1;
            load_data  = 32'h0000_0400;
            load_dp    = dp_pat[p];
            lit_cycles = 0;
            for (int c = 0; c < 2 * FRAME; c++) begin
                tick();
                load_valid = 1'b0;
                if (c >= FRAME && anodes != 8'hFF) lit_cycles++;
                checks++;
                if ({anodes, cathodes, frame_done, load_ready} !== {exp_an, exp_cat, exp_fd, m_ready}) begin
                    errors++;
                    $display("FAIL lzb t=%0d: got an=%h cat=%h fd=%b rdy=%b, expected an=%h cat=%h fd=%b rdy=%b",
                             t, anodes, cathodes, frame_done, load_ready, exp_an, exp_cat, exp_fd, m_ready);
                end
            end
            checks++;
            if (lit_cycles != expected[p]) begin
                errors++;
                $display("FAIL lzb_lit dp=%h: got %0d lit cycles, expected %0d", dp_pat[p], lit_cycles, expected[p]);
            end
        end
    endtask

    // Random frames, dp, brightness and load_valid (also while not ready)
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 8 * FRAME; c++) begin
            brightness = 4'($urandom);
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = $urandom >> $urandom_range(0, 31);
            load_dp    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            tick();
            checks++;
            if ({anodes, cathodes, frame_done, load_ready} !== {exp_an, exp_cat, exp_fd, m_ready}) begin
                errors++;
                $display("FAIL random t=%0d: got an=%h cat=%h fd=%b rdy=%b, expected an=%h cat=%h fd=%b rdy=%b",
                         t, anodes, cathodes, frame_done, load_ready, exp_an, exp_cat, exp_fd, m_ready);
            end
        end
        load_valid = 1'b0;
        brightness = 4'hF;
    endtask

    // Three-digit instance: anodes 6,5,3 and frame_done every third slot
    task automatic test_three_digits();
        int fd_count;
        fd_count = 0;
        do_reset();
        for (int c = 0; c < 6 * 3 * SLOT; c++) begin
            tick();
            if (frame_done3) fd_count++;
            checks++;
            if ({anodes3, frame_done3} !== {exp3_an, exp3_fd}) begin
                errors++;
                $display("FAIL three_digits t=%0d: got an=%b fd=%b, expected an=%b fd=%b",
                         t, anodes3, frame_done3, exp3_an, exp3_fd);
            end
        end
        checks++;
        if (fd_count != 6) begin
            errors++;
            $display("FAIL three_digits_fd: got %0d frame_done pulses, expected 6", fd_count);
        end
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_data   = '0;
        load_dp     = '0;
        brightness  = 4'hF;
        load_valid3 = 1'b1;
        load_data3  = 12'h321;
        load_dp3    = 3'b000;
        brightness3 = 4'hF;
        test_reset();
        test_basic_scan();
        test_brightness();
        test_boundary_load();
        test_reset_mid();
        test_lzb();
        test_random();
        test_three_digits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Backstop against a hung run
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
